// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller: FSM states, forward selects, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIRE  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int EXIT_CODE_DEF    = 10;
    localparam int DRAIN_CYCLES_DEF = 3;

    // $zero is hardwired, so a write to it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller (stage register fields in, control out).
// Latency: n/a (wires only).
// Backpressure: stall/flush outputs are the pipeline's only backpressure.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs_D, rt_D, rs_E, rt_E;
    logic [4:0]       writeReg_E, writeReg_M, writeReg_W;
    logic             regWrite_E, regWrite_M, regWrite_W;
    logic             memToReg_E, memToReg_M;
    logic             branch_D, jump_D, jr_D, PCSrc_D, syscall_D;
    logic [31:0]      v0;

    logic             stall_F, stall_D, flush_D, flush_E;
    logic             forwardA_D, forwardB_D;
    logic [1:0]       forwardA_E, forwardB_E;
    logic             syscall_go, halted;
    logic [CNT_W-1:0] stall_count, flush_count, cycle_count;

    modport master (
        output rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W,
               regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M,
               branch_D, jump_D, jr_D, PCSrc_D, syscall_D, v0,
        input  stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D,
               forwardA_E, forwardB_E, syscall_go, halted,
               stall_count, flush_count, cycle_count
    );

    modport slave (
        input  rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W,
               regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M,
               branch_D, jump_D, jr_D, PCSrc_D, syscall_D, v0,
        output stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D,
               forwardA_E, forwardB_E, syscall_go, halted,
               stall_count, flush_count, cycle_count
    );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Forward unit for one source operand: EX-stage bypass select and ID-stage compare bypass.
// Latency: combinational.
// Backpressure: none.
module hazard_controller_forward_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] src_E,
    input  logic [4:0] src_D,
    input  logic [4:0] writeReg_M,
    input  logic [4:0] writeReg_W,
    input  logic       regWrite_M,
    input  logic       regWrite_W,
    output logic [1:0] fwd_E,
    output logic       fwd_D
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_E = FWD_RF;
        if (regWrite_M && reg_match(writeReg_M, src_E))
            fwd_E = FWD_MEM;
        else if (regWrite_W && reg_match(writeReg_W, src_E))
            fwd_E = FWD_WB;
    end

    assign fwd_D = regWrite_M && reg_match(writeReg_M, src_D);

endmodule

// File: rtl/hazard_controller.sv
// MIPS 5-stage hazard controller: forwarding, load-use/branch stalls, flushes, syscall drain, halt, stats.
// Latency: stalls/flushes/forwards combinational; syscall_go DRAIN_CYCLES+1 cycles after syscall enters ID.
// Backpressure: holds IF/ID via stall_F/stall_D and bubbles EX via flush_E; HALT stalls until reset.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] EXIT_CODE    = 32'(EXIT_CODE_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    hazard_controller_if.slave hif
);

    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t           state;
    logic [DCW-1:0]   drain_cnt;
    logic             resume_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, cyc_cnt;

    logic lwstall, brstall, hazard, ctrl_xfer;
    logic stall_any, flush_d, flush_e;

    hazard_controller_forward_unit u_fwd_a (
        .src_E      (hif.rs_E),
        .src_D      (hif.rs_D),
        .writeReg_M (hif.writeReg_M),
        .writeReg_W (hif.writeReg_W),
        .regWrite_M (hif.regWrite_M),
        .regWrite_W (hif.regWrite_W),
        .fwd_E      (hif.forwardA_E),
        .fwd_D      (hif.forwardA_D)
    );

    hazard_controller_forward_unit u_fwd_b (
        .src_E      (hif.rt_E),
        .src_D      (hif.rt_D),
        .writeReg_M (hif.writeReg_M),
        .writeReg_W (hif.writeReg_W),
        .regWrite_M (hif.regWrite_M),
        .regWrite_W (hif.regWrite_W),
        .fwd_E      (hif.forwardB_E),
        .fwd_D      (hif.forwardB_D)
    );

    assign lwstall = hif.memToReg_E &&
                     (reg_match(hif.rt_E, hif.rs_D) || reg_match(hif.rt_E, hif.rt_D));

    // Branch compare and jr read registers in ID, so an ALU result still in EX
    // or a load still in MEM cannot be bypassed in time.
    assign brstall = (hif.branch_D || hif.jr_D) &&
                     ((hif.regWrite_E && (reg_match(hif.writeReg_E, hif.rs_D) ||
                                          reg_match(hif.writeReg_E, hif.rt_D))) ||
                      (hif.memToReg_M && (reg_match(hif.writeReg_M, hif.rs_D) ||
                                          reg_match(hif.writeReg_M, hif.rt_D))));

    assign hazard    = lwstall || brstall;
    assign ctrl_xfer = hif.PCSrc_D || hif.jump_D || hif.jr_D;

    always_comb begin
        stall_any = 1'b1;
        flush_d   = 1'b0;
        flush_e   = 1'b1;
        if (state == ST_RUN) begin
            stall_any = hazard;
            flush_e   = hazard;
            flush_d   = resume_flush || (ctrl_xfer && !hazard);
        end
    end

    assign hif.stall_F     = stall_any;
    assign hif.stall_D     = stall_any;
    assign hif.flush_D     = flush_d;
    assign hif.flush_E     = flush_e;
    assign hif.syscall_go  = (state == ST_FIRE);
    assign hif.halted      = (state == ST_HALT);
    assign hif.stall_count = stall_cnt;
    assign hif.flush_count = flush_cnt;
    assign hif.cycle_count = cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            drain_cnt    <= '0;
            resume_flush <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            cyc_cnt      <= '0;
        end else begin
            resume_flush <= 1'b0;
            unique case (state)
                // The syscall is still sitting in ID during the resume cycle; it must not re-arm.
                ST_RUN: begin
                    if (hif.syscall_D && !hazard && !resume_flush) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - DCW'(1);
                    if (drain_cnt == DCW'(1))
                        state <= ST_FIRE;
                end
                ST_FIRE: begin
                    if (hif.v0 == EXIT_CODE) begin
                        state <= ST_HALT;
                    end else begin
                        state        <= ST_RUN;
                        resume_flush <= 1'b1;
                    end
                end
                ST_HALT: state <= ST_HALT;
            endcase

            if (state != ST_HALT) begin
                if (stall_any && !(&stall_cnt))
                    stall_cnt <= stall_cnt + CNT_W'(1);
                if ((flush_d || flush_e) && !(&flush_cnt))
                    flush_cnt <= flush_cnt + CNT_W'(1);
                if (!(&cyc_cnt))
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, stalls, flushes, syscall drain/halt, counters.
// Latency: checks combinational outputs 4 time units after each rising edge.
// Backpressure: n/a.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if              hif ();
    hazard_controller_if #(.CNT_W(3)) sif ();

    hazard_controller u_dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    hazard_controller #(.CNT_W(3)) u_sat (
        .clk   (clk),
        .reset (reset),
        .hif   (sif.slave)
    );

    int tests = 0;
    int fails = 0;

    // {stall_F, stall_D, flush_D, flush_E, syscall_go, halted}
    logic [5:0]  ctl;
    // {forwardA_D, forwardB_D, forwardA_E, forwardB_E}
    logic [5:0]  fwd;
    // {stall_count, flush_count, cycle_count}
    logic [95:0] cnts;
    assign ctl  = {hif.stall_F, hif.stall_D, hif.flush_D, hif.flush_E, hif.syscall_go, hif.halted};
    assign fwd  = {hif.forwardA_D, hif.forwardB_D, hif.forwardA_E, hif.forwardB_E};
    assign cnts = {hif.stall_count, hif.flush_count, hif.cycle_count};

    task automatic idle();
        hif.rs_D = 5'd0; hif.rt_D = 5'd0; hif.rs_E = 5'd0; hif.rt_E = 5'd0;
        hif.writeReg_E = 5'd0; hif.writeReg_M = 5'd0; hif.writeReg_W = 5'd0;
        hif.regWrite_E = 1'b0; hif.regWrite_M = 1'b0; hif.regWrite_W = 1'b0;
        hif.memToReg_E = 1'b0; hif.memToReg_M = 1'b0;
        hif.branch_D = 1'b0; hif.jump_D = 1'b0; hif.jr_D = 1'b0;
        hif.PCSrc_D = 1'b0; hif.syscall_D = 1'b0; hif.v0 = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b000000); end
        tests++; if (fwd !== 6'b000000) begin fails++; $display("FAIL reset_fwd: got %b want %b", fwd, 6'b000000); end
        tests++; if (cnts !== 96'd0) begin fails++; $display("FAIL reset_cnts: got %h want 0", cnts); end
    endtask

    task automatic test_forward_ex();
        next_cycle(); idle();
        hif.rs_E = 5'd8; hif.rt_E = 5'd9;
        hif.regWrite_M = 1'b1; hif.writeReg_M = 5'd8;
        hif.regWrite_W = 1'b1; hif.writeReg_W = 5'd8;
        #3;
        tests++; if (fwd !== 6'b00_10_00) begin fails++; $display("FAIL fwd_mem_prio: got %b want %b", fwd, 6'b00_10_00); end
        next_cycle();
        hif.writeReg_M = 5'd5; hif.writeReg_W = 5'd9;
        #3;
        tests++; if (fwd !== 6'b00_00_01) begin fails++; $display("FAIL fwd_wb_b: got %b want %b", fwd, 6'b00_00_01); end
        next_cycle();
        hif.regWrite_M = 1'b1; hif.writeReg_M = 5'd8;
        hif.regWrite_W = 1'b1; hif.writeReg_W = 5'd8;
        hif.rs_E = 5'd3; hif.rt_E = 5'd8; hif.rs_D = 5'd3; hif.rt_D = 5'd8;
        #3;
        tests++; if (fwd !== 6'b01_00_10) begin fails++; $display("FAIL fwd_d_b: got %b want %b", fwd, 6'b01_00_10); end
        next_cycle(); idle();
        hif.rs_E = 5'd8; hif.regWrite_W = 1'b1; hif.writeReg_W = 5'd8;
        #3;
        tests++; if (fwd !== 6'b00_01_00) begin fails++; $display("FAIL fwd_2apart: got %b want %b", fwd, 6'b00_01_00); end
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL fwd_no_stall: got %b want %b", ctl, 6'b000000); end
    endtask

    task automatic test_zero_reg();
        next_cycle(); idle();
        hif.regWrite_M = 1'b1; hif.regWrite_W = 1'b1; hif.regWrite_E = 1'b1;
        hif.memToReg_E = 1'b1; hif.memToReg_M = 1'b1; hif.branch_D = 1'b1;
        #3;
        tests++; if (fwd !== 6'b000000) begin fails++; $display("FAIL zero_fwd: got %b want %b", fwd, 6'b000000); end
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL zero_ctl: got %b want %b", ctl, 6'b000000); end
    endtask

    task automatic test_load_use();
        do_reset();
        hif.memToReg_E = 1'b1; hif.regWrite_E = 1'b1; hif.writeReg_E = 5'd8; hif.rt_E = 5'd8;
        hif.rs_D = 5'd8; hif.rt_D = 5'd9;
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL lw_stall: got %b want %b", ctl, 6'b110100); end
        next_cycle(); idle();
        hif.memToReg_M = 1'b1; hif.regWrite_M = 1'b1; hif.writeReg_M = 5'd8;
        hif.rs_D = 5'd8; hif.rt_D = 5'd9;
        #3;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL lw_release: got %b want %b", ctl, 6'b000000); end
        next_cycle(); idle();
        hif.regWrite_W = 1'b1; hif.writeReg_W = 5'd8; hif.rs_E = 5'd8; hif.rt_E = 5'd9;
        #3;
        tests++; if (fwd !== 6'b00_01_00) begin fails++; $display("FAIL lw_fwd_wb: got %b want %b", fwd, 6'b00_01_00); end
        tests++; if (cnts !== {32'd1, 32'd1, 32'd2}) begin fails++; $display("FAIL lw_cnts: got %h want %h", cnts, {32'd1, 32'd1, 32'd2}); end
    endtask

    task automatic test_branch();
        do_reset();
        hif.regWrite_E = 1'b1; hif.writeReg_E = 5'd8;
        hif.branch_D = 1'b1; hif.rs_D = 5'd8; hif.rt_D = 5'd9; hif.PCSrc_D = 1'b1;
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL br_stall: got %b want %b", ctl, 6'b110100); end
        next_cycle();
        hif.regWrite_E = 1'b0; hif.writeReg_E = 5'd0;
        hif.regWrite_M = 1'b1; hif.writeReg_M = 5'd8;
        #3;
        tests++; if (ctl !== 6'b001000) begin fails++; $display("FAIL br_flush: got %b want %b", ctl, 6'b001000); end
        tests++; if (fwd !== 6'b10_00_00) begin fails++; $display("FAIL br_fwd_d: got %b want %b", fwd, 6'b10_00_00); end
        next_cycle(); idle();
        #3;
        tests++; if (cnts !== {32'd1, 32'd2, 32'd2}) begin fails++; $display("FAIL br_cnts: got %h want %h", cnts, {32'd1, 32'd2, 32'd2}); end
        next_cycle(); idle();
        hif.memToReg_M = 1'b1; hif.regWrite_M = 1'b1; hif.writeReg_M = 5'd9;
        hif.branch_D = 1'b1; hif.rs_D = 5'd4; hif.rt_D = 5'd9;
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL br_load_mem: got %b want %b", ctl, 6'b110100); end
        next_cycle(); idle();
        hif.jr_D = 1'b1; hif.rs_D = 5'd7; hif.regWrite_E = 1'b1; hif.writeReg_E = 5'd7;
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL jr_stall: got %b want %b", ctl, 6'b110100); end
        next_cycle(); idle();
        hif.jump_D = 1'b1;
        #3;
        tests++; if (ctl !== 6'b001000) begin fails++; $display("FAIL jump_flush: got %b want %b", ctl, 6'b001000); end
    endtask

    task automatic test_syscall_resume();
        logic [5:0] exp_seq [7];
        exp_seq = '{6'b000000, 6'b110100, 6'b110100, 6'b110100, 6'b110110, 6'b001000, 6'b000000};
        do_reset();
        hif.syscall_D = 1'b1; hif.v0 = 32'd1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            if (c == 6) hif.syscall_D = 1'b0;
            #3;
            tests++;
            if (ctl !== exp_seq[c]) begin fails++; $display("FAIL sys_seq[%0d]: got %b want %b", c, ctl, exp_seq[c]); end
        end
        tests++; if (cnts !== {32'd4, 32'd5, 32'd6}) begin fails++; $display("FAIL sys_cnts: got %h want %h", cnts, {32'd4, 32'd5, 32'd6}); end
    endtask

    task automatic test_syscall_hazard();
        do_reset();
        hif.syscall_D = 1'b1; hif.v0 = 32'd1;
        hif.memToReg_E = 1'b1; hif.rt_E = 5'd8; hif.rs_D = 5'd8;
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL sys_haz_stall: got %b want %b", ctl, 6'b110100); end
        next_cycle();
        hif.memToReg_E = 1'b0;
        #3;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL sys_haz_wait: got %b want %b", ctl, 6'b000000); end
        next_cycle();
        #3;
        tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL sys_haz_drain: got %b want %b", ctl, 6'b110100); end
        do_reset();
        #3;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL drain_reset_ctl: got %b want %b", ctl, 6'b000000); end
        tests++; if (cnts !== 96'd0) begin fails++; $display("FAIL drain_reset_cnts: got %h want 0", cnts); end
    endtask

    task automatic test_halt();
        logic [5:0] exp_seq [6];
        exp_seq = '{6'b000000, 6'b110100, 6'b110100, 6'b110100, 6'b110110, 6'b110101};
        do_reset();
        hif.syscall_D = 1'b1; hif.v0 = 32'd10;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            if (c == 5) hif.syscall_D = 1'b0;
            #3;
            tests++;
            if (ctl !== exp_seq[c]) begin fails++; $display("FAIL halt_seq[%0d]: got %b want %b", c, ctl, exp_seq[c]); end
        end
        tests++; if (cnts !== {32'd4, 32'd4, 32'd5}) begin fails++; $display("FAIL halt_cnts: got %h want %h", cnts, {32'd4, 32'd4, 32'd5}); end
        for (int c = 0; c < 3; c++) next_cycle();
        hif.memToReg_E = 1'b1; hif.rt_E = 5'd8; hif.rs_D = 5'd8; hif.jump_D = 1'b1; hif.syscall_D = 1'b1;
        #3;
        tests++; if (ctl !== 6'b110101) begin fails++; $display("FAIL halt_sticky: got %b want %b", ctl, 6'b110101); end
        tests++; if (cnts !== {32'd4, 32'd4, 32'd5}) begin fails++; $display("FAIL halt_frozen: got %h want %h", cnts, {32'd4, 32'd4, 32'd5}); end
        do_reset();
        #3;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL halt_reset_ctl: got %b want %b", ctl, 6'b000000); end
        tests++; if (cnts !== 96'd0) begin fails++; $display("FAIL halt_reset_cnts: got %h want 0", cnts); end
        next_cycle();
        #3;
        tests++; if (hif.cycle_count !== 32'd1) begin fails++; $display("FAIL halt_restart_cyc: got %0d want 1", hif.cycle_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        #3;
        tests++; if (sif.cycle_count !== 3'd0) begin fails++; $display("FAIL sat_start: got %0d want 0", sif.cycle_count); end
        for (int c = 0; c < 5; c++) next_cycle();
        #3;
        tests++; if (sif.cycle_count !== 3'd5) begin fails++; $display("FAIL sat_mid: got %0d want 5", sif.cycle_count); end
        for (int c = 0; c < 6; c++) next_cycle();
        #3;
        tests++; if (sif.cycle_count !== 3'd7) begin fails++; $display("FAIL sat_hold: got %0d want 7", sif.cycle_count); end
        tests++; if (sif.stall_count !== 3'd0) begin fails++; $display("FAIL sat_stall: got %0d want 0", sif.stall_count); end
    endtask

    initial begin
        sif.rs_D = 5'd0; sif.rt_D = 5'd0; sif.rs_E = 5'd0; sif.rt_E = 5'd0;
        sif.writeReg_E = 5'd0; sif.writeReg_M = 5'd0; sif.writeReg_W = 5'd0;
        sif.regWrite_E = 1'b0; sif.regWrite_M = 1'b0; sif.regWrite_W = 1'b0;
        sif.memToReg_E = 1'b0; sif.memToReg_M = 1'b0;
        sif.branch_D = 1'b0; sif.jump_D = 1'b0; sif.jr_D = 1'b0;
        sif.PCSrc_D = 1'b0; sif.syscall_D = 1'b0; sif.v0 = 32'd0;
        idle();

        test_reset();
        test_forward_ex();
        test_zero_reg();
        test_load_use();
        test_branch();
        test_syscall_resume();
        test_syscall_hazard();
        test_halt();
        test_saturate();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
